// File: rtl/risc_dmem_master.sv
// Data-memory bus initiator: sequences one load/store at a time through
// SETUP/ACCESS/HOLD so address and data never move while the memory is writing.
module risc_dmem_master #(
  parameter int AW          = 4,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          dmenbl,
  output logic [AW-1:0] dmaddr,
  output logic [DW-1:0] dmdatain,
  output logic          rdwr,
  input  logic [DW-1:0] dmdataout,
  output logic [7:0]    xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_RESP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_store;
  logic [3:0] r_wait;
  logic       w_accept;
  logic       w_access_done;
  logic       w_resp_done;

  assign req_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_access_done = 1'b0;
    w_resp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (r_wait == 4'd0) begin
          w_access_done = 1'b1;
          w_state_nxt   = S_HOLD;
        end
      end
      S_HOLD:   w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_resp_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // All bus strobes are registered; dmaddr/dmdatain double as the request
  // latches and only load on accept, when rdwr is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store    <= 1'b0;
      r_wait     <= 4'd0;
      rdwr       <= 1'b1;
      dmenbl     <= 1'b0;
      dmaddr     <= '0;
      dmdatain   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      xfer_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        dmaddr   <= req_addr;
        dmdatain <= req_wdata;
        dmenbl   <= 1'b1;
      end
      if (r_state == S_SETUP) begin
        rdwr   <= ~r_store;
        r_wait <= 4'(WAIT_CYCLES);
      end
      if ((r_state == S_ACCESS) && !w_access_done) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_access_done) begin
        rdwr <= 1'b1;
        if (!r_store) rsp_rdata <= dmdataout;
      end
      if (r_state == S_HOLD) begin
        dmenbl    <= 1'b0;
        rsp_valid <= 1'b1;
      end
      if (w_resp_done) begin
        rsp_valid  <= 1'b0;
        xfer_count <= xfer_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_risc_dmem_master.sv
// Bench for risc_dmem_master: two instances (WAIT_CYCLES 0 and 3) on behavioural
// memories, checked against an array-based reference of memory and load data.
module tb_risc_dmem_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_init;
  logic       req_valid [2];
  logic       req_store [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_ready [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       dmenbl    [2];
  logic [3:0] dmaddr    [2];
  logic [7:0] dmdatain  [2];
  logic       rdwr      [2];
  logic [7:0] dmdataout [2];
  logic [7:0] xfer_count[2];

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [2][16];
  logic [7:0] ref_last[2];
  int         ref_cnt [2];

  always #5 clk = ~clk;

  risc_dmem_master #(.AW(4), .DW(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .dmenbl(dmenbl[0]), .dmaddr(dmaddr[0]), .dmdatain(dmdatain[0]), .rdwr(rdwr[0]),
    .dmdataout(dmdataout[0]), .xfer_count(xfer_count[0]));

  risc_dmem_master #(.AW(4), .DW(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .dmenbl(dmenbl[1]), .dmaddr(dmaddr[1]), .dmdatain(dmdatain[1]), .rdwr(rdwr[1]),
    .dmdataout(dmdataout[1]), .xfer_count(xfer_count[1]));

  // Behavioural memories: combinational read, write during any cycle with rdwr=0.
  logic [7:0] mem [2][16];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= 8'(i * 34);
      end else if (dmenbl[k] === 1'b1 && rdwr[k] === 1'b0) begin
        mem[k][dmaddr[k]] <= dmdatain[k];
      end
    end
  end
  assign dmdataout[0] = mem[0][dmaddr[0]];
  assign dmdataout[1] = mem[1][dmaddr[1]];

  // Bus monitor: cycles with rdwr low, and address/data moves not bracketed by rdwr=1.
  int         lowcnt[2];
  int         viol  [2];
  logic       primed;
  logic [3:0] p_addr[2];
  logic [7:0] p_data[2];
  logic       p_rdwr[2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (primed && (dmaddr[k] !== p_addr[k] || dmdatain[k] !== p_data[k]) &&
            !(p_rdwr[k] === 1'b1 && rdwr[k] === 1'b1))
          viol[k] <= viol[k] + 1;
        if (rdwr[k] === 1'b0) lowcnt[k] <= lowcnt[k] + 1;
        p_addr[k] <= dmaddr[k];
        p_data[k] <= dmdatain[k];
        p_rdwr[k] <= rdwr[k];
      end
    end
  end

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) ref_mem[k][i] = 8'(i * 34);
    end
    @(negedge clk); mem_init = 1'b1;
    @(negedge clk); mem_init = 1'b0;
  endtask

  task automatic model_xfer(input int k, input logic st, input logic [3:0] a,
                            input logic [7:0] d, output logic [7:0] exp_rd);
    if (st) ref_mem[k][a] = d;
    else    ref_last[k] = ref_mem[k][a];
    exp_rd = ref_last[k];
    ref_cnt[k] = ref_cnt[k] + 1;
  endtask

  // One transfer; returns latency in edges after accept, load data, rdwr-low
  // cycles, monitor violations, and whether the held response stayed put.
  task automatic xfer(input int k, input logic st, input logic [3:0] a, input logic [7:0] d,
                      input int hold, output int lat, output logic [7:0] rd,
                      output int low, output int vio, output logic ok);
    int low0;
    int vio0;
    int n;
    logic [3:0] a_seen;
    low0 = lowcnt[k];
    vio0 = viol[k];
    ok = 1'b1;
    @(negedge clk);
    req_valid[k] = 1'b1; req_store[k] = st; req_addr[k] = a; req_wdata[k] = d;
    rsp_ready[k] = 1'b0;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid[k] !== 1'b1 && lat < 40);
    rd = rsp_rdata[k];
    a_seen = dmaddr[k];
    repeat (hold) begin
      req_valid[k] = 1'b1; req_addr[k] = ~a;
      @(negedge clk);
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd || req_ready[k] !== 1'b0 ||
          dmenbl[k] !== 1'b0 || dmaddr[k] !== a_seen) ok = 1'b0;
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) ok = 1'b0;
    low = lowcnt[k] - low0;
    vio = viol[k] - vio0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_init = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_store[k] = 1'b0; req_addr[k] = 4'h0;
      req_wdata[k] = 8'h00; rsp_ready[k] = 1'b0;
      ref_last[k] = 8'h00; ref_cnt[k] = 0;
    end
    model_init();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rdwr[k], dmenbl[k], dmaddr[k], dmdatain[k], rsp_valid[k], rsp_rdata[k],
           xfer_count[k], req_ready[k]} !==
          {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL reset_state[%0d] got rdwr=%b en=%b addr=%h din=%h rv=%b rd=%h cnt=%h rr=%b want 1 0 0 00 0 00 00 1",
                 k, rdwr[k], dmenbl[k], dmaddr[k], dmdatain[k], rsp_valid[k],
                 rsp_rdata[k], xfer_count[k], req_ready[k]);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    req_valid[1] = 1'b1; req_store[1] = 1'b1; req_addr[1] = 4'h3; req_wdata[1] = 8'hC3;
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdwr[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_store_rdwr got %b want 0", rdwr[1]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdwr[1] !== 1'b1 || dmenbl[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got rdwr=%b en=%b rv=%b want 1 0 0",
               rdwr[1], dmenbl[1], rsp_valid[1]);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin ref_last[k] = 8'h00; ref_cnt[k] = 0; end
    model_init();
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid[1] !== 1'b0 || xfer_count[1] !== 8'h00 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL no_response_after_reset got rv=%b cnt=%h rr=%b want 0 00 1",
               rsp_valid[1], xfer_count[1], req_ready[1]);
    end
  endtask

  task automatic test_load_w0();
    int lat; int low; int vio; logic ok; logic [7:0] rd; logic [7:0] exp_rd;
    model_xfer(0, 1'b0, 4'h4, 8'h00, exp_rd);
    xfer(0, 1'b0, 4'h4, 8'h00, 0, lat, rd, low, vio, ok);
    checks++;
    if (rd !== exp_rd || rd !== 8'h88) begin
      errors++; $display("FAIL load4_data got %h want %h", rd, exp_rd);
    end
    checks++;
    if (lat !== 3 || low !== 0 || ok !== 1'b1) begin
      errors++; $display("FAIL load4_timing got lat=%0d low=%0d ok=%b want 3 0 1", lat, low, ok);
    end
  endtask

  task automatic test_store_load();
    int lat; int low; int vio; logic ok; logic [7:0] rd; logic [7:0] exp_rd;
    model_xfer(0, 1'b1, 4'h9, 8'h5A, exp_rd);
    xfer(0, 1'b1, 4'h9, 8'h5A, 0, lat, rd, low, vio, ok);
    checks++;
    if (rd !== exp_rd || lat !== 3 || low !== 1 || vio !== 0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL store9 got rd=%h lat=%0d low=%0d vio=%0d ok=%b want %h 3 1 0 1",
               rd, lat, low, vio, ok, exp_rd);
    end
    model_xfer(0, 1'b0, 4'h9, 8'h00, exp_rd);
    xfer(0, 1'b0, 4'h9, 8'h00, 0, lat, rd, low, vio, ok);
    checks++;
    if (rd !== exp_rd || rd !== 8'h5A || low !== 0 || vio !== 0) begin
      errors++;
      $display("FAIL load9 got rd=%h low=%0d vio=%0d want %h 0 0", rd, low, vio, exp_rd);
    end
  endtask

  task automatic test_wait3();
    int lat; int low; int vio; logic ok; logic [7:0] rd; logic [7:0] exp_rd; logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    model_xfer(1, 1'b1, 4'hA, d, exp_rd);
    xfer(1, 1'b1, 4'hA, d, 0, lat, rd, low, vio, ok);
    checks++;
    if (low !== 4 || lat !== 6 || vio !== 0 || rd !== exp_rd) begin
      errors++;
      $display("FAIL w3_store got low=%0d lat=%0d vio=%0d rd=%h want 4 6 0 %h",
               low, lat, vio, rd, exp_rd);
    end
    model_xfer(1, 1'b0, 4'hA, 8'h00, exp_rd);
    xfer(1, 1'b0, 4'hA, 8'h00, 0, lat, rd, low, vio, ok);
    checks++;
    if (rd !== exp_rd || rd !== d || lat !== 6 || low !== 0) begin
      errors++;
      $display("FAIL w3_load got rd=%h lat=%0d low=%0d want %h 6 0", rd, lat, low, d);
    end
  endtask

  task automatic test_backpressure();
    int lat; int low; int vio; logic ok; logic [7:0] rd; logic [7:0] exp_rd; logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    model_xfer(0, 1'b0, a, 8'h00, exp_rd);
    xfer(0, 1'b0, a, 8'h00, 5, lat, rd, low, vio, ok);
    checks++;
    if (ok !== 1'b1 || rd !== exp_rd) begin
      errors++; $display("FAIL backpressure got ok=%b rd=%h want 1 %h", ok, rd, exp_rd);
    end
    checks++;
    if (xfer_count[0] !== 8'(ref_cnt[0])) begin
      errors++; $display("FAIL count_after_hold got %0d want %0d", xfer_count[0], 8'(ref_cnt[0]));
    end
  endtask

  task automatic test_random_wrap();
    int lat; int low; int vio; logic ok; logic [7:0] rd; logic [7:0] exp_rd;
    logic st; logic [3:0] a; logic [7:0] d; logic [7:0] start;
    start = xfer_count[0];
    for (int i = 0; i < 256; i++) begin
      st = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      model_xfer(0, st, a, d, exp_rd);
      xfer(0, st, a, d, 0, lat, rd, low, vio, ok);
      checks++;
      if (rd !== exp_rd || lat !== 3 || low !== (st ? 1 : 0) || vio !== 0 || ok !== 1'b1) begin
        errors++;
        $display("FAIL rand0[%0d] st=%b a=%h got rd=%h lat=%0d low=%0d vio=%0d ok=%b want %h 3 %0d 0 1",
                 i, st, a, rd, lat, low, vio, ok, exp_rd, st ? 1 : 0);
      end
    end
    checks++;
    if (xfer_count[0] !== start || xfer_count[0] !== 8'(ref_cnt[0])) begin
      errors++;
      $display("FAIL count_wrap got %0d want %0d", xfer_count[0], start);
    end
    for (int i = 0; i < 24; i++) begin
      st = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      model_xfer(1, st, a, d, exp_rd);
      xfer(1, st, a, d, 0, lat, rd, low, vio, ok);
      checks++;
      if (rd !== exp_rd || lat !== 6 || low !== (st ? 4 : 0) || vio !== 0) begin
        errors++;
        $display("FAIL rand3[%0d] st=%b a=%h got rd=%h lat=%0d low=%0d vio=%0d want %h 6 %0d 0",
                 i, st, a, rd, lat, low, vio, exp_rd, st ? 4 : 0);
      end
    end
    model_init();
    model_xfer(0, 1'b1, 4'hF, 8'hFF, exp_rd);
    xfer(0, 1'b1, 4'hF, 8'hFF, 0, lat, rd, low, vio, ok);
    model_xfer(0, 1'b0, 4'h0, 8'h00, exp_rd);
    xfer(0, 1'b0, 4'h0, 8'h00, 0, lat, rd, low, vio, ok);
    checks++;
    if (rd !== exp_rd || rd !== 8'h00) begin
      errors++; $display("FAIL addr_edge got %h want %h", rd, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_store();
    test_load_w0();
    test_store_load();
    test_wait3();
    test_backpressure();
    test_random_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
